// File: rtl/rvfi_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_csr_pkg
//  Description : Shared definitions for the mcycle/minstret CSR counter unit:
//                CSR address constants, Zicsr op encoding, RVFI half masks,
//                response-FSM state type and the address canonicalisation
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvfi_csr_pkg;

    // CSR addresses owned by the unit. CSR_NONE marks an address that does
    // not decode to any counter.
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_NONE      = 12'hFFF;

    localparam logic [1:0]  MODE_M        = 2'd3;

    // Zicsr funct3[1:0]; encoding 0 is never issued to this unit.
    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd1,
        CSR_OP_RS = 2'd2,
        CSR_OP_RC = 2'd3
    } csr_op_e;

    localparam logic [63:0] MASK_LO  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MASK_HI  = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] MASK_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } csr_state_e;

    // One RVFI CSR record (rmask/wmask/rdata/wdata) for a single counter.
    typedef struct packed {
        logic [63:0] rmask;
        logic [63:0] wmask;
        logic [63:0] rdata;
        logic [63:0] wdata;
    } rvfi_csr_t;

    // Folds the user-level aliases onto their machine-level address so the
    // datapath only has to distinguish four targets. High-half addresses
    // exist only on RV32 (has_hi=1).
    function automatic logic [11:0] canon_addr(input logic [11:0] addr,
                                               input logic        has_hi);
        logic [11:0] r;
        case (addr)
            CSR_MCYCLE,   CSR_CYCLE:    r = CSR_MCYCLE;
            CSR_MINSTRET, CSR_INSTRET:  r = CSR_MINSTRET;
            CSR_MCYCLEH,  CSR_CYCLEH:   r = has_hi ? CSR_MCYCLEH   : CSR_NONE;
            CSR_MINSTRETH, CSR_INSTRETH: r = has_hi ? CSR_MINSTRETH : CSR_NONE;
            default:                    r = CSR_NONE;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_csr_counter64
//  Description : 64-bit free-running counter with independent 32-bit half
//                write enables. A write to either half takes precedence over
//                the increment in the same cycle; the unwritten half keeps
//                its pre-write value. Wraps from all-ones to zero.
//  Ports       : clock      - rising-edge clock
//                reset      - synchronous, active-low
//                i_inc      - increment request
//                i_we_lo    - replace bits [31:0] with i_wdata[31:0]
//                i_we_hi    - replace bits [63:32] with i_wdata[63:32]
//                i_wdata    - write data
//                o_value    - current counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module rvfi_csr_counter64 #(
    parameter logic [63:0] RST_VALUE = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_value
);

    logic [63:0] r_value;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_value <= RST_VALUE;
        end else if (i_we_lo || i_we_hi) begin
            r_value <= {i_we_hi ? i_wdata[63:32] : r_value[63:32],
                        i_we_lo ? i_wdata[31:0]  : r_value[31:0]};
        end else if (i_inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/rvfi_csr_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_csr_counter_unit
//  Description : Owns mcycle/minstret and executes Zicsr instructions that
//                target them, producing the resp_* result and the RVFI CSR
//                fields for both counters. One request in flight: accepted in
//                IDLE, result held in RESP until resp_ready.
//  Config      : CSR_COUNTER_USER_ALIAS_EN - when defined, the C-space
//                read-only aliases are readable from any privilege mode;
//                otherwise they are readable from M-mode only.
//  Ports       : clock, reset (sync, active-low)
//                req_valid/req_ready, req_addr, req_op, req_arg, req_wr,
//                req_rd, req_mode      - CSR instruction in
//                retire                - minstret increment
//                resp_valid/resp_ready, resp_rdata, resp_illegal - result out
//                rvfi_csr_{mcycle,minstret}_{rmask,wmask,rdata,wdata}
//                                      - RVFI fields, valid with resp_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module rvfi_csr_counter_unit
    import rvfi_csr_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [63:0] MCYCLE_RST = 64'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_arg,
    input  logic            req_wr,
    input  logic            req_rd,
    input  logic [1:0]      req_mode,
    input  logic            retire,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic [63:0]     rvfi_csr_mcycle_rmask,
    output logic [63:0]     rvfi_csr_mcycle_wmask,
    output logic [63:0]     rvfi_csr_mcycle_rdata,
    output logic [63:0]     rvfi_csr_mcycle_wdata,
    output logic [63:0]     rvfi_csr_minstret_rmask,
    output logic [63:0]     rvfi_csr_minstret_wmask,
    output logic [63:0]     rvfi_csr_minstret_rdata,
    output logic [63:0]     rvfi_csr_minstret_wdata
);

    localparam logic c_has_hi = (XLEN == 32);

    csr_state_e  r_state;
    logic [XLEN-1:0] r_resp_rdata;
    logic        r_resp_illegal;
    rvfi_csr_t   r_rvfi_mc;
    rvfi_csr_t   r_rvfi_mi;

    logic [11:0] w_canon;
    logic        w_sel_instret;
    logic        w_cspace;
    logic        w_is_m;
    logic        w_alias_ok;
    logic        w_illegal;
    logic        w_accept;
    logic        w_do_write;
    logic        w_we_lo;
    logic        w_we_hi;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [63:0] w_old64;
    logic [63:0] w_wr64;
    logic [63:0] w_wdata64;
    logic [63:0] w_half_mask;
    logic [XLEN-1:0] w_old_half;
    logic [XLEN-1:0] w_new_half;
    rvfi_csr_t   w_rvfi_tgt;

    // ------------------------------------------------------------------
    // Decode and legality
    // ------------------------------------------------------------------
    assign w_canon       = canon_addr(req_addr, c_has_hi);
    assign w_sel_instret = (w_canon == CSR_MINSTRET) || (w_canon == CSR_MINSTRETH);
    assign w_cspace      = (req_addr[11:8] == 4'hC);
    assign w_is_m        = (req_mode == MODE_M);

`ifdef CSR_COUNTER_USER_ALIAS_EN
    assign w_alias_ok = 1'b1;
`else
    assign w_alias_ok = w_is_m;
`endif

    // A decoded address is always in B- or C-space, so !w_cspace means B.
    assign w_illegal = (w_canon == CSR_NONE)
                    || (!w_cspace && !w_is_m)
                    || (w_cspace && req_wr)
                    || (w_cspace && !w_alias_ok);

    assign w_accept   = reset && (r_state == ST_IDLE) && req_valid;
    assign w_do_write = w_accept && !w_illegal && req_wr;

    assign w_old64 = w_sel_instret ? w_minstret : w_mcycle;

    // ------------------------------------------------------------------
    // XLEN-specific half selection
    // ------------------------------------------------------------------
    generate
        if (XLEN == 32) begin : g_rv32
            logic w_hi;
            assign w_hi        = (w_canon == CSR_MCYCLEH) || (w_canon == CSR_MINSTRETH);
            assign w_old_half  = w_hi ? w_old64[63:32] : w_old64[31:0];
            assign w_half_mask = w_hi ? MASK_HI : MASK_LO;
            assign w_we_lo     = !w_hi;
            assign w_we_hi     = w_hi;
            assign w_wdata64   = {w_new_half, w_new_half};
            assign w_wr64      = w_hi ? {w_new_half, w_old64[31:0]}
                                      : {w_old64[63:32], w_new_half};
        end else begin : g_rv64
            assign w_old_half  = w_old64;
            assign w_half_mask = MASK_ALL;
            assign w_we_lo     = 1'b1;
            assign w_we_hi     = 1'b1;
            assign w_wdata64   = w_new_half;
            assign w_wr64      = w_new_half;
        end
    endgenerate

    always_comb begin
        w_new_half = w_old_half;
        case (csr_op_e'(req_op))
            CSR_OP_RW: w_new_half = req_arg;
            CSR_OP_RS: w_new_half = w_old_half | req_arg;
            CSR_OP_RC: w_new_half = w_old_half & ~req_arg;
            default:   w_new_half = w_old_half;
        endcase
    end

    // RVFI record for the addressed counter; post-write value equals the
    // pre-write value when the instruction does not write.
    always_comb begin
        w_rvfi_tgt       = '0;
        w_rvfi_tgt.rmask = req_rd ? w_half_mask : 64'd0;
        w_rvfi_tgt.wmask = req_wr ? w_half_mask : 64'd0;
        w_rvfi_tgt.rdata = w_old64;
        w_rvfi_tgt.wdata = req_wr ? w_wr64 : w_old64;
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    rvfi_csr_counter64 #(
        .RST_VALUE (MCYCLE_RST)
    ) u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_we_lo (w_do_write && !w_sel_instret && w_we_lo),
        .i_we_hi (w_do_write && !w_sel_instret && w_we_hi),
        .i_wdata (w_wdata64),
        .o_value (w_mcycle)
    );

    rvfi_csr_counter64 #(
        .RST_VALUE (64'd0)
    ) u_minstret (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (retire),
        .i_we_lo (w_do_write && w_sel_instret && w_we_lo),
        .i_we_hi (w_do_write && w_sel_instret && w_we_hi),
        .i_wdata (w_wdata64),
        .o_value (w_minstret)
    );

    // ------------------------------------------------------------------
    // Response FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_resp_rdata   <= '0;
            r_resp_illegal <= 1'b0;
            r_rvfi_mc      <= '0;
            r_rvfi_mi      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state        <= ST_RESP;
                        r_resp_illegal <= w_illegal;
                        r_resp_rdata   <= (!w_illegal && req_rd) ? w_old_half : '0;
                        r_rvfi_mc      <= (!w_illegal && !w_sel_instret) ? w_rvfi_tgt : '0;
                        r_rvfi_mi      <= (!w_illegal &&  w_sel_instret) ? w_rvfi_tgt : '0;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state        <= ST_IDLE;
                        r_resp_rdata   <= '0;
                        r_resp_illegal <= 1'b0;
                        r_rvfi_mc      <= '0;
                        r_rvfi_mi      <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_rdata   = r_resp_rdata;
    assign resp_illegal = r_resp_illegal;

    assign rvfi_csr_mcycle_rmask   = r_rvfi_mc.rmask;
    assign rvfi_csr_mcycle_wmask   = r_rvfi_mc.wmask;
    assign rvfi_csr_mcycle_rdata   = r_rvfi_mc.rdata;
    assign rvfi_csr_mcycle_wdata   = r_rvfi_mc.wdata;
    assign rvfi_csr_minstret_rmask = r_rvfi_mi.rmask;
    assign rvfi_csr_minstret_wmask = r_rvfi_mi.wmask;
    assign rvfi_csr_minstret_rdata = r_rvfi_mi.rdata;
    assign rvfi_csr_minstret_wdata = r_rvfi_mi.wdata;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_csr_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfi_csr_counter_unit
//  Description : Self-checking bench for rvfi_csr_counter_unit (XLEN=32).
//                A cycle-level reference model tracks both counters as plain
//                64-bit integers and predicts every response; directed
//                sequences are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_csr_counter_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_arg;
    logic        req_wr;
    logic        req_rd;
    logic [1:0]  req_mode;
    logic        retire;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [63:0] mc_rmask, mc_wmask, mc_rdata, mc_wdata;
    logic [63:0] mi_rmask, mi_wmask, mi_rdata, mi_wdata;

    rvfi_csr_counter_unit #(
        .XLEN       (32),
        .MCYCLE_RST (64'd0)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_addr                (req_addr),
        .req_op                  (req_op),
        .req_arg                 (req_arg),
        .req_wr                  (req_wr),
        .req_rd                  (req_rd),
        .req_mode                (req_mode),
        .retire                  (retire),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_rdata              (resp_rdata),
        .resp_illegal            (resp_illegal),
        .rvfi_csr_mcycle_rmask   (mc_rmask),
        .rvfi_csr_mcycle_wmask   (mc_wmask),
        .rvfi_csr_mcycle_rdata   (mc_rdata),
        .rvfi_csr_mcycle_wdata   (mc_wdata),
        .rvfi_csr_minstret_rmask (mi_rmask),
        .rvfi_csr_minstret_wmask (mi_wmask),
        .rvfi_csr_minstret_rdata (mi_rdata),
        .rvfi_csr_minstret_wdata (mi_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef CSR_COUNTER_USER_ALIAS_EN
    localparam bit c_alias = 1'b1;
`else
    localparam bit c_alias = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_cycle, m_instret;
    bit          m_busy;
    logic [31:0] e_rdata;
    bit          e_ill;
    logic [63:0] e_mc [4];   // rmask, wmask, rdata, wdata
    logic [63:0] e_mi [4];

    logic [11:0] addr_tab [10];

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict the effect of the next rising edge from the currently driven
    // inputs, advance one clock, then compare.
    task automatic step();
        logic [63:0] nc, ni, old, post, mask;
        logic [31:0] half, nv;
        bit known, is_cyc, is_hi, legal, acc;
        if (!reset) begin
            m_cycle = 64'd0; m_instret = 64'd0; m_busy = 0;
        end else begin
            nc  = m_cycle + 64'd1;
            ni  = m_instret + (retire ? 64'd1 : 64'd0);
            acc = !m_busy && req_valid;
            if (m_busy && resp_ready) m_busy = 0;
            if (acc) begin
                known = 1; is_cyc = 0; is_hi = 0;
                case (req_addr)
                    12'hB00, 12'hC00: begin is_cyc = 1; is_hi = 0; end
                    12'hB02, 12'hC02: begin is_cyc = 0; is_hi = 0; end
                    12'hB80, 12'hC80: begin is_cyc = 1; is_hi = 1; end
                    12'hB82, 12'hC82: begin is_cyc = 0; is_hi = 1; end
                    default: known = 0;
                endcase
                if (req_addr[11:8] == 4'hB) legal = known && (req_mode == 2'd3);
                else legal = known && !req_wr && (c_alias || req_mode == 2'd3);
                e_ill = !legal; e_rdata = 0;
                for (int k = 0; k < 4; k++) begin e_mc[k] = 0; e_mi[k] = 0; end
                if (legal) begin
                    old  = is_cyc ? m_cycle : m_instret;
                    half = is_hi ? old[63:32] : old[31:0];
                    case (req_op)
                        2'd1:    nv = req_arg;
                        2'd2:    nv = half | req_arg;
                        default: nv = half & ~req_arg;
                    endcase
                    post = old;
                    if (req_wr) begin
                        if (is_hi) post[63:32] = nv; else post[31:0] = nv;
                    end
                    mask    = is_hi ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
                    e_rdata = req_rd ? half : 32'd0;
                    if (is_cyc) begin
                        e_mc[0] = req_rd ? mask : 0; e_mc[1] = req_wr ? mask : 0;
                        e_mc[2] = old; e_mc[3] = post;
                        if (req_wr) nc = post;
                    end else begin
                        e_mi[0] = req_rd ? mask : 0; e_mi[1] = req_wr ? mask : 0;
                        e_mi[2] = old; e_mi[3] = post;
                        if (req_wr) ni = post;
                    end
                end
                m_busy = 1;
            end
            m_cycle = nc; m_instret = ni;
        end
        @(posedge clock);
        #1;
        check_value("req_ready", req_ready, !m_busy);
        check_value("resp_valid", resp_valid, m_busy);
        if (!reset) begin
            check_value("rst_rdata", resp_rdata, 0);
            check_value("rst_illegal", resp_illegal, 0);
            check_value("rst_mc_rmask", mc_rmask, 0);
            check_value("rst_mc_wmask", mc_wmask, 0);
            check_value("rst_mc_rdata", mc_rdata, 0);
            check_value("rst_mc_wdata", mc_wdata, 0);
            check_value("rst_mi_rmask", mi_rmask, 0);
            check_value("rst_mi_wmask", mi_wmask, 0);
            check_value("rst_mi_rdata", mi_rdata, 0);
            check_value("rst_mi_wdata", mi_wdata, 0);
        end else if (m_busy) begin
            check_value("resp_rdata", resp_rdata, e_rdata);
            check_value("resp_illegal", resp_illegal, e_ill);
            check_value("mc_rmask", mc_rmask, e_mc[0]);
            check_value("mc_wmask", mc_wmask, e_mc[1]);
            check_value("mi_rmask", mi_rmask, e_mi[0]);
            check_value("mi_wmask", mi_wmask, e_mi[1]);
            if (!e_ill) begin
                check_value("mc_rdata", mc_rdata, e_mc[2]);
                check_value("mc_wdata", mc_wdata, e_mc[3]);
                check_value("mi_rdata", mi_rdata, e_mi[2]);
                check_value("mi_wdata", mi_wdata, e_mi[3]);
            end
        end
    endtask

    // Offer one request for one cycle (accepted if idle); caller completes it.
    task automatic issue(input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] arg, input bit wr, input bit rd,
                         input logic [1:0] mode, input bit ret);
        req_valid = 1; req_addr = a; req_op = op; req_arg = arg;
        req_wr = wr; req_rd = rd; req_mode = mode; retire = ret;
        step();
        req_valid = 0; retire = 0;
    endtask

    initial begin
        addr_tab = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                     12'hC02, 12'hC80, 12'hC82, 12'hB01, 12'hFFF};
        reset = 0; req_valid = 0; req_addr = 0; req_op = 2'd1; req_arg = 0;
        req_wr = 0; req_rd = 0; req_mode = 2'd3; retire = 0; resp_ready = 1;

        // Reset held three cycles, then three free-running cycles
        repeat (3) step();
        reset = 1;
        repeat (3) step();
        issue(12'hC00, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t1_cycle_after_reset", resp_rdata, 32'd3);
        step();

        // CSRRW mcycle with mcycle = 0x1_0000_00FF at acceptance
        issue(12'hB80, 2'd1, 32'h1, 1, 1, 2'd3, 0); step();
        issue(12'hB00, 2'd1, 32'hFE, 1, 1, 2'd3, 0); step();
        issue(12'hB00, 2'd1, 32'h1234, 1, 1, 2'd3, 0);
        check_value("t2_rdata", resp_rdata, 32'h0000_00FF);
        check_value("t2_wdata", mc_wdata, 64'h1_0000_1234);
        check_value("t2_wmask", mc_wmask, 64'h0000_0000_FFFF_FFFF);
        step();
        issue(12'hB00, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t2_after", resp_rdata, 32'h1235);
        step();

        // CSRRS minstreth with retire in the same cycle
        issue(12'hB02, 2'd1, 32'h5, 1, 0, 2'd3, 0); step();
        issue(12'hB82, 2'd2, 32'h1, 1, 1, 2'd3, 1);
        check_value("t3_wdata", mi_wdata, 64'h1_0000_0005);
        step();
        issue(12'hB02, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t3_no_inc", resp_rdata, 32'h5);
        step();

        // Privilege / write-to-read-only legality
        issue(12'hB02, 2'd1, 32'h77, 1, 1, 2'd0, 1);
        check_value("t4_u_write_illegal", resp_illegal, 1);
        step();
        issue(12'hC00, 2'd2, 0, 0, 1, 2'd0, 0); step();
        issue(12'hC02, 2'd1, 32'h1, 1, 1, 2'd3, 0); step();
        issue(12'hB02, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t4_unchanged", resp_rdata, 32'h6);
        step();

        // 64-bit wrap of mcycle, then clear the high half
        issue(12'hB80, 2'd1, 32'hFFFF_FFFF, 1, 0, 2'd3, 0); step();
        issue(12'hB00, 2'd1, 32'hFFFF_FFFE, 1, 0, 2'd3, 0); step();
        issue(12'hB80, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t5_all_ones", mc_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        issue(12'hB80, 2'd2, 0, 0, 1, 2'd3, 0);
        check_value("t5_wrapped_hi", resp_rdata, 32'h0);
        step();
        issue(12'hB80, 2'd3, 32'hFFFF_FFFF, 1, 1, 2'd3, 0); step();

        // Back-pressure, then reset while a response is pending
        resp_ready = 0;
        issue(12'hB02, 2'd3, 32'h3, 1, 1, 2'd3, 1);
        req_valid = 1; req_addr = 12'hB00;
        repeat (4) step();
        reset = 0; step();
        reset = 1; req_valid = 0; resp_ready = 1;
        issue(12'hB02, 2'd2, 0, 0, 1, 2'd3, 0); step();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            reset      = ($urandom_range(0, 99) != 0);
            req_valid  = $urandom_range(0, 1);
            req_addr   = addr_tab[$urandom_range(0, 9)];
            req_op     = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0:       req_arg = 32'hFFFF_FFFF;
                1:       req_arg = 32'($urandom_range(0, 15));
                default: req_arg = $urandom;
            endcase
            req_wr     = $urandom_range(0, 1);
            req_rd     = $urandom_range(0, 1);
            req_mode   = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'd3;
            retire     = $urandom_range(0, 1);
            resp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
